sw_lap_controller: RTL and testbench

- Control sequencer for the 4-digit BCD stopwatch datapath (0.1 s / 1 s / 10 s / 100 s counters).
- Turns two debounced buttons into run/stop, lap capture with display freeze, lap recall and clear.
- Owns an 8-entry lap-time buffer and selects what the 7-seg multiplexer shows: live time, frozen split or recalled lap.
- Sits between the debounce logic and the counter chain / display scan.

---
 rtl/sw_lap_if.sv | 47 ++++
 rtl/sw_lap_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_sw_lap_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_lap_if.sv
//----------------------------------------------------------------------------
// sw_lap_if
//   Bundles the stopwatch lap controller's signals. The controller side
//   (slave) receives the debounced button levels, the 0.1 s tick and the
//   live BCD time. It returns the counter-chain controls and the display
//   value. The master side is whoever drives the controller (button and
//   debounce logic, counter chain, or a testbench).
//
//   btn_start  debounced start/stop level, synchronous to clk0
//   btn_lap    debounced lap/recall/clear level, synchronous to clk0
//   tick_01s   one-cycle 0.1 s enable from the counter chain
//   time_bcd   live time {sec100, sec10, sec1, decisec}, BCD
//   run        count enable to the counter chain
//   clear      one-cycle synchronous clear to the counter chain
//   disp_bcd   value for the display scan
//   state_o    FSM state code for LEDs
//   lap_cnt    number of stored laps (0..DEPTH)
//   lap_full   lap_cnt == DEPTH
//----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sw_lap_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             btn_start;
    logic             btn_lap;
    logic             tick_01s;
    logic [15:0]      time_bcd;
    logic             run;
    logic             clear;
    logic [15:0]      disp_bcd;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] lap_cnt;
    logic             lap_full;

    modport master (
        output btn_start, btn_lap, tick_01s, time_bcd,
        input  run, clear, disp_bcd, state_o, lap_cnt, lap_full
    );

    modport slave (
        input  btn_start, btn_lap, tick_01s, time_bcd,
        output run, clear, disp_bcd, state_o, lap_cnt, lap_full
    );
endinterface

// File: rtl/sw_lap_controller.sv
//----------------------------------------------------------------------------
// sw_lap_controller
//   Control sequencer for a 4-digit BCD stopwatch. It turns the debounced
//   start and lap buttons into the following actions:
//     - run/stop of the counter chain
//     - lap capture with a timed display freeze
//     - recall of stored laps
//     - clear
//   Stored laps live in a DEPTH-entry buffer. The controller also chooses
//   what the display shows: live time, the frozen split, or a recalled lap.
//
//   Ports:
//     clk0      system clock
//     reset_sw  asynchronous, active-high reset
//     bus       sw_lap_if.slave (see rtl/sw_lap_if.sv for the signal list)
//
//   Parameters:
//     DEPTH       lap buffer entries (power of 2, >= 2)
//     HOLD_TICKS  tick_01s pulses a split stays frozen before the display
//                 returns to live time
//
//   Every output is registered. A button edge sampled at clock edge k
//   changes the outputs right after edge k.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module sw_lap_controller #(
    parameter int DEPTH      = 8,
    parameter int HOLD_TICKS = 30
) (
    input  logic    clk0,
    input  logic    reset_sw,
    sw_lap_if.slave bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SPLIT  = 3'd2,
        STOP   = 3'd3,
        RECALL = 3'd4
    } state_t;

    state_t            state_q;
    logic              run_q;
    logic              clear_q;
    logic [15:0]       disp_q;
    logic [CNT_W-1:0]  lap_cnt_q;
    logic              lap_full_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [HOLD_W-1:0] hold_q;
    logic              start_prev_q;
    logic              lap_prev_q;

    logic [15:0]       lap_buf [DEPTH];

    // Button edges. When both buttons rise together, start wins and the
    // lap edge is dropped.
    logic start_e;
    logic lap_e;
    assign start_e = bus.btn_start & ~start_prev_q;
    assign lap_e   = bus.btn_lap & ~lap_prev_q & ~start_e;

    // A lap edge while counting always freezes the display. It is stored
    // only while the buffer still has room.
    logic capture;
    logic wr_en;
    assign capture = lap_e & ((state_q == RUN) | (state_q == SPLIT));
    assign wr_en   = capture & ~lap_full_q;

    logic             last_entry;
    logic [PTR_W-1:0] rd_ptr_inc;
    assign last_entry = ({1'b0, rd_ptr_q} == (lap_cnt_q - CNT_W'(1)));
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    // Clear happens in two cases:
    //   - a lap press in STOP with no laps stored
    //   - a lap press on the last recalled entry
    logic clr_go;
    assign clr_go = lap_e & (((state_q == STOP) & (lap_cnt_q == '0)) |
                             ((state_q == RECALL) & last_entry));

    // NOTE: the lap buffer has no reset. It is written before it is ever
    // read, so resetting it would only add logic.
    always_ff @(posedge clk0) begin
        if (wr_en) begin
            lap_buf[lap_cnt_q[PTR_W-1:0]] <= bus.time_bcd;
        end
    end

    // NOTE: every register below uses non-blocking assignment. Later
    // assignments in the same cycle override the defaults set earlier in the
    // block, and no register sees another register's new value in the same
    // cycle.
    always_ff @(posedge clk0 or posedge reset_sw) begin
        if (reset_sw) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            clear_q      <= 1'b0;
            disp_q       <= '0;
            lap_cnt_q    <= '0;
            lap_full_q   <= 1'b0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            start_prev_q <= 1'b0;
            lap_prev_q   <= 1'b0;
        end else begin
            start_prev_q <= bus.btn_start;
            lap_prev_q   <= bus.btn_lap;
            clear_q      <= 1'b0;

            if (wr_en) begin
                lap_cnt_q  <= lap_cnt_q + CNT_W'(1);
                lap_full_q <= (lap_cnt_q == CNT_W'(DEPTH - 1));
            end

            if (clr_go) begin
                clear_q    <= 1'b1;
                lap_cnt_q  <= '0;
                lap_full_q <= 1'b0;
                rd_ptr_q   <= '0;
            end

            case (state_q)
                IDLE: begin
                    run_q  <= 1'b0;
                    disp_q <= bus.time_bcd;
                    if (start_e) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end

                RUN: begin
                    run_q  <= 1'b1;
                    disp_q <= bus.time_bcd;
                    if (start_e) begin
                        state_q <= STOP;
                        run_q   <= 1'b0;
                    end else if (lap_e) begin
                        state_q <= SPLIT;
                        hold_q  <= '0;
                    end
                end

                SPLIT: begin
                    // Counting continues. disp_q keeps the frozen value
                    // unless something below replaces it.
                    run_q <= 1'b1;
                    if (start_e) begin
                        state_q <= STOP;
                        run_q   <= 1'b0;
                        disp_q  <= bus.time_bcd;
                    end else if (lap_e) begin
                        disp_q <= bus.time_bcd;
                        hold_q <= '0;
                    end else if (bus.tick_01s) begin
                        if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                            state_q <= RUN;
                            disp_q  <= bus.time_bcd;
                            hold_q  <= '0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end

                STOP: begin
                    run_q  <= 1'b0;
                    disp_q <= bus.time_bcd;
                    if (start_e) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else if (lap_e) begin
                        if (lap_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q  <= RECALL;
                            rd_ptr_q <= '0;
                            disp_q   <= lap_buf[0];
                        end
                    end
                end

                RECALL: begin
                    run_q  <= 1'b0;
                    disp_q <= lap_buf[rd_ptr_q];
                    if (start_e) begin
                        state_q <= STOP;
                        disp_q  <= bus.time_bcd;
                    end else if (lap_e) begin
                        if (last_entry) begin
                            state_q <= IDLE;
                            disp_q  <= bus.time_bcd;
                        end else begin
                            rd_ptr_q <= rd_ptr_inc;
                            disp_q   <= lap_buf[rd_ptr_inc];
                        end
                    end
                end

                default: begin
                    // Codes 5..7 are not valid states. Recover to IDLE.
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                    disp_q  <= bus.time_bcd;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign bus.run      = run_q;
    assign bus.clear    = clear_q;
    assign bus.disp_bcd = disp_q;
    assign bus.state_o  = state_q;
    assign bus.lap_cnt  = lap_cnt_q;
    assign bus.lap_full = lap_full_q;

endmodule

// File: tb/tb_sw_lap_controller.sv
//----------------------------------------------------------------------------
// tb_sw_lap_controller
//   Directed bench for sw_lap_controller (DEPTH=8, HOLD_TICKS=30). Outputs
//   are sampled 1 ns after the rising clock edge. Inputs change at that
//   same point, so they are stable well before the next edge.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sw_lap_controller;

    logic clk0     = 1'b0;
    logic reset_sw = 1'b1;

    int checks   = 0;
    int failures = 0;

    sw_lap_if #(.DEPTH(8)) bus ();

    sw_lap_controller #(.DEPTH(8), .HOLD_TICKS(30)) dut (
        .clk0     (clk0),
        .reset_sw (reset_sw),
        .bus      (bus)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // Each pulse first spends one cycle low. That guarantees the history
    // flop is 0, so the following high cycle is seen as a rising edge.
    task automatic pulse_start();
        step();
        bus.btn_start = 1'b1;
        step();
        bus.btn_start = 1'b0;
    endtask

    task automatic pulse_lap();
        step();
        bus.btn_lap = 1'b1;
        step();
        bus.btn_lap = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick_01s = 1'b1;
        step();
        bus.tick_01s = 1'b0;
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_lap   = 1'b0;
        bus.tick_01s  = 1'b0;
        bus.time_bcd  = 16'h0000;

        // Reset
        step();
        step();
        reset_sw = 1'b0;
        check("rst_state", bus.state_o, 3'd0);
        check("rst_run", bus.run, 1'b0);
        check("rst_clear", bus.clear, 1'b0);
        check("rst_disp", bus.disp_bcd, 16'h0000);
        check("rst_lap_cnt", bus.lap_cnt, 4'd0);
        check("rst_lap_full", bus.lap_full, 1'b0);

        // Start / stop / resume
        pulse_start();
        check("start_run", bus.run, 1'b1);
        check("start_state", bus.state_o, 3'd1);
        pulse_start();
        check("stop_run", bus.run, 1'b0);
        check("stop_state", bus.state_o, 3'd3);
        pulse_start();
        check("resume_state", bus.state_o, 3'd1);

        // Split capture, freeze, then auto-return after 30 ticks
        bus.time_bcd = 16'h0123;
        pulse_lap();
        check("split_state", bus.state_o, 3'd2);
        check("split_disp", bus.disp_bcd, 16'h0123);
        check("split_lap_cnt", bus.lap_cnt, 4'd1);
        bus.time_bcd = 16'h0456;
        step();
        check("split_frozen", bus.disp_bcd, 16'h0123);
        check("split_run", bus.run, 1'b1);
        for (int i = 0; i < 29; i++) pulse_tick();
        check("hold29_state", bus.state_o, 3'd2);
        check("hold29_disp", bus.disp_bcd, 16'h0123);
        pulse_tick();
        check("hold30_state", bus.state_o, 3'd1);
        check("hold30_disp", bus.disp_bcd, 16'h0456);

        // Simultaneous start and lap edges: start wins
        step();
        bus.btn_start = 1'b1;
        bus.btn_lap   = 1'b1;
        step();
        bus.btn_start = 1'b0;
        bus.btn_lap   = 1'b0;
        check("both_state", bus.state_o, 3'd3);
        check("both_lap_cnt", bus.lap_cnt, 4'd1);
        check("both_disp", bus.disp_bcd, 16'h0456);

        // Recall the single lap, then clear
        pulse_lap();
        check("rc1_state", bus.state_o, 3'd4);
        check("rc1_disp", bus.disp_bcd, 16'h0123);
        pulse_lap();
        check("rc1_clear", bus.clear, 1'b1);
        check("rc1_clr_state", bus.state_o, 3'd0);
        check("rc1_clr_cnt", bus.lap_cnt, 4'd0);
        step();
        check("rc1_clear_off", bus.clear, 1'b0);

        // Fill the buffer: 9 laps at times 0001..0009
        pulse_start();
        for (int i = 1; i <= 7; i++) begin
            bus.time_bcd = 16'(i);
            pulse_lap();
        end
        check("fill7_cnt", bus.lap_cnt, 4'd7);
        check("fill7_full", bus.lap_full, 1'b0);
        bus.time_bcd = 16'h0008;
        pulse_lap();
        check("fill8_cnt", bus.lap_cnt, 4'd8);
        check("fill8_full", bus.lap_full, 1'b1);
        bus.time_bcd = 16'h0009;
        pulse_lap();
        check("fill9_disp", bus.disp_bcd, 16'h0009);
        check("fill9_cnt", bus.lap_cnt, 4'd8);
        check("fill9_state", bus.state_o, 3'd2);
        check("fill9_full", bus.lap_full, 1'b1);

        // Stop from SPLIT, then recall all 8 entries (the 9th lap was not stored)
        bus.time_bcd = 16'h0100;
        pulse_start();
        check("fstop_state", bus.state_o, 3'd3);
        check("fstop_disp", bus.disp_bcd, 16'h0100);
        for (int k = 1; k <= 8; k++) begin
            pulse_lap();
            check("frecall_disp", bus.disp_bcd, 32'(k));
        end
        check("frecall_state", bus.state_o, 3'd4);
        pulse_lap();
        check("fclr_clear", bus.clear, 1'b1);
        check("fclr_full", bus.lap_full, 1'b0);
        check("fclr_cnt", bus.lap_cnt, 4'd0);
        check("fclr_state", bus.state_o, 3'd0);

        // Three laps, stop, recall x3, then clear on the 4th press
        pulse_start();
        bus.time_bcd = 16'h0010;
        pulse_lap();
        bus.time_bcd = 16'h0020;
        pulse_lap();
        bus.time_bcd = 16'h0030;
        pulse_lap();
        check("l3_cnt", bus.lap_cnt, 4'd3);
        bus.time_bcd = 16'h0031;
        pulse_start();
        check("l3_stop_state", bus.state_o, 3'd3);
        check("l3_stop_disp", bus.disp_bcd, 16'h0031);
        pulse_lap();
        check("l3_rc0", bus.disp_bcd, 16'h0010);
        pulse_lap();
        check("l3_rc1", bus.disp_bcd, 16'h0020);
        pulse_lap();
        check("l3_rc2", bus.disp_bcd, 16'h0030);
        pulse_lap();
        check("l3_clear", bus.clear, 1'b1);
        check("l3_clr_state", bus.state_o, 3'd0);
        check("l3_clr_cnt", bus.lap_cnt, 4'd0);
        check("l3_clr_run", bus.run, 1'b0);
        step();
        check("l3_clear_off", bus.clear, 1'b0);

        // Leave RECALL with start, then re-enter (read pointer restarts)
        pulse_start();
        bus.time_bcd = 16'h0040;
        pulse_lap();
        bus.time_bcd = 16'h0050;
        pulse_lap();
        pulse_start();
        pulse_lap();
        check("l2_rc0", bus.disp_bcd, 16'h0040);
        pulse_lap();
        check("l2_rc1", bus.disp_bcd, 16'h0050);
        pulse_start();
        check("l2_stop_state", bus.state_o, 3'd3);
        check("l2_stop_cnt", bus.lap_cnt, 4'd2);
        pulse_lap();
        check("l2_reenter_state", bus.state_o, 3'd4);
        check("l2_reenter_disp", bus.disp_bcd, 16'h0040);

        // Asynchronous reset mid-RECALL, between clock edges
        #3;
        reset_sw = 1'b1;
        #1;
        check("arst_state", bus.state_o, 3'd0);
        check("arst_run", bus.run, 1'b0);
        check("arst_clear", bus.clear, 1'b0);
        check("arst_disp", bus.disp_bcd, 16'h0000);
        check("arst_cnt", bus.lap_cnt, 4'd0);
        check("arst_full", bus.lap_full, 1'b0);
        #2;
        reset_sw = 1'b0;
        step();
        check("post_rst_state", bus.state_o, 3'd0);
        check("post_rst_clear", bus.clear, 1'b0);
        check("post_rst_disp", bus.disp_bcd, 16'h0050);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
